clock_divider_bank: RTL

//   Multi-channel programmable clock/tick generator; parametrised successor to the fixed 25_000 divider.

---
 rtl/clock_divider_bank.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/clock_divider_bank.sv
// clock_divider_bank
//   Multi-channel programmable clock/tick generator. Each channel divides the
//   system clock into a 50%-duty clock whose half period is active_div+1 cycles
//   and emits a one-cycle tick in every cycle its divided clock toggles.
//   Divisors are written into a per-channel shadow register and reach the live
//   counter only at a terminal count or at start-up, so a divisor change never
//   produces a truncated phase.
//
// Ports
//   clk_i       system clock, all logic on posedge
//   rst_ni      asynchronous active-low reset
//   cfg_we_i    one-cycle divisor write strobe
//   cfg_addr_i  channel index for the write (indices >= NUM_CH are ignored)
//   cfg_div_i   divisor value to write
//   ch_en_i     per-channel run enable (level)
//   clkd_o      divided clock per channel
//   tick_o      one-cycle strobe, high in the cycle clkd_o toggles
//   running_o   high while a channel is in RUN or STOPPING
module clock_divider_bank #(
  parameter int               NUM_CH      = 4,
  parameter int               CNT_W       = 32,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(25000),
  localparam int              CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cfg_we_i,
  input  logic [CH_W-1:0]   cfg_addr_i,
  input  logic [CNT_W-1:0]  cfg_div_i,
  input  logic [NUM_CH-1:0] ch_en_i,
  output logic [NUM_CH-1:0] clkd_o,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] running_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STOP = 2'b10
  } state_t;

  state_t           state_q [NUM_CH];
  state_t           state_d [NUM_CH];
  logic [CNT_W-1:0] ctr_q   [NUM_CH];
  logic [CNT_W-1:0] ctr_d   [NUM_CH];
  logic [CNT_W-1:0] act_q   [NUM_CH];
  logic [CNT_W-1:0] act_d   [NUM_CH];
  logic [CNT_W-1:0] shd_q   [NUM_CH];
  logic [CNT_W-1:0] shd_d   [NUM_CH];
  logic [NUM_CH-1:0] clkd_q, clkd_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] run_q,  run_d;

  // Next-state logic for every channel: shadow write, counting, and run/stop FSM.
  always_comb begin
    logic tc;
    tc = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      ctr_d[i]   = ctr_q[i];
      act_d[i]   = act_q[i];
      shd_d[i]   = shd_q[i];
      clkd_d[i]  = clkd_q[i];
      tick_d[i]  = 1'b0;

      // Out-of-range addresses never match any loop index, so they are dropped.
      if (cfg_we_i && (cfg_addr_i == CH_W'(i))) begin
        shd_d[i] = cfg_div_i;
      end else begin
        shd_d[i] = shd_q[i];
      end

      tc = (state_q[i] != ST_IDLE) && (ctr_q[i] == act_q[i]);

      case (state_q[i])
        ST_IDLE: begin
          ctr_d[i]  = '0;
          clkd_d[i] = 1'b0;
          if (ch_en_i[i]) begin
            state_d[i] = ST_RUN;
            act_d[i]   = shd_q[i];
          end else begin
            state_d[i] = ST_IDLE;
          end
        end

        ST_RUN, ST_STOP: begin
          if (!ch_en_i[i] && !clkd_q[i]) begin
            // Low phase: stopping now cannot shorten a high pulse.
            state_d[i] = ST_IDLE;
            ctr_d[i]   = '0;
          end else begin
            // TC loads the shadow as it stood before this edge, so a write in
            // the TC cycle only applies from the following TC.
            if (tc) begin
              ctr_d[i]  = '0;
              clkd_d[i] = ~clkd_q[i];
              tick_d[i] = 1'b1;
              act_d[i]  = shd_q[i];
            end else begin
              ctr_d[i]  = ctr_q[i] + CNT_W'(1);
            end

            if (ch_en_i[i]) begin
              state_d[i] = ST_RUN;
            end else if (tc) begin
              // High phase just completed with enable low: clkd falls, go idle.
              state_d[i] = ST_IDLE;
            end else begin
              state_d[i] = ST_STOP;
            end
          end
        end

        default: begin
          state_d[i] = ST_IDLE;
          ctr_d[i]   = '0;
          clkd_d[i]  = 1'b0;
        end
      endcase

      run_d[i] = (state_d[i] != ST_IDLE);
    end
  end

  // Channel state registers with asynchronous reset to the idle defaults.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_IDLE;
        ctr_q[i]   <= '0;
        act_q[i]   <= DEFAULT_DIV;
        shd_q[i]   <= DEFAULT_DIV;
      end
      clkd_q <= '0;
      tick_q <= '0;
      run_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        ctr_q[i]   <= ctr_d[i];
        act_q[i]   <= act_d[i];
        shd_q[i]   <= shd_d[i];
      end
      clkd_q <= clkd_d;
      tick_q <= tick_d;
      run_q  <= run_d;
    end
  end

  assign clkd_o    = clkd_q;
  assign tick_o    = tick_q;
  assign running_o = run_q;

endmodule
